// File: rtl/store_rmw_ctrl_if.sv
// Store request and word-memory port bundle for the
// sub-word read-modify-write store controller.
interface store_rmw_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_type;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              done;
  logic              err;

  modport master (
    output req_valid,
    output req_type,
    output req_addr,
    output req_wdata,
    output mem_rdata,
    input  req_ready,
    input  mem_en,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  done,
    input  err
  );

  modport slave (
    input  req_valid,
    input  req_type,
    input  req_addr,
    input  req_wdata,
    input  mem_rdata,
    output req_ready,
    output mem_en,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output done,
    output err
  );
endinterface

// File: rtl/store_rmw_ctrl.sv
// Store controller: word stores write directly, half/byte
// stores read the word, merge the new lane(s), write back.
module store_rmw_ctrl #(
  parameter int ADDR_W = 32
) (
  input logic            clk,
  input logic            reset,
  store_rmw_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    MG,
    WR
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [1:0]        typ;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       merged;
  logic [31:0]       merge;
  logic              done_q;
  logic              err_q;
  logic              illegal;
  logic              accept;
  logic              reject;
  logic              req_ready;
  logic              mem_en;
  logic              mem_we;

  always_comb begin
    illegal = 1'b0;
    case (bus.req_type)
      2'b00:   illegal = (bus.req_addr[1:0] != 2'b00);
      2'b01:   illegal = bus.req_addr[0];
      2'b10:   illegal = 1'b0;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    merge = bus.mem_rdata;
    if (typ == 2'b01) begin
      if (addr[1]) merge[31:16] = wdata[15:0];
      else         merge[15:0]  = wdata[15:0];
    end else begin
      merge[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
    end
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          if (illegal) begin
            reject = 1'b1;
          end else begin
            accept   = 1'b1;
            state_nx = (bus.req_type == 2'b00) ? WR : RD;
          end
        end
      end
      RD: begin
        mem_en   = 1'b1;
        state_nx = MG;
      end
      MG: begin
        state_nx = WR;
      end
      WR: begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      typ    <= '0;
      addr   <= '0;
      wdata  <= '0;
      merged <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= (state == WR);
      err_q  <= reject;
      if (accept) begin
        typ   <= bus.req_type;
        addr  <= bus.req_addr;
        wdata <= bus.req_wdata;
      end
      if (state == MG) merged <= merge;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = {addr[ADDR_W-1:2], 2'b00};
  // Word stores bypass the merge register entirely.
  assign bus.mem_wdata = (typ == 2'b00) ? wdata : merged;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Bench for store_rmw_ctrl: cycle-level schedule model
// plus word-memory model, with directed store vectors.
module tb_store_rmw_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  store_rmw_ctrl_if #(.ADDR_W(32)) bus();

  store_rmw_ctrl #(.ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Memory the DUT talks to
  logic [31:0] mem [256];
  logic [31:0] last_wr_addr;
  logic [31:0] last_wr_data;
  int          wr_count = 0;
  int          rd_count = 0;

  always @(posedge clk) begin
    if (bus.mem_en && !bus.mem_we) begin
      bus.mem_rdata <= mem[bus.mem_addr[9:2]];
      rd_count      <= rd_count + 1;
    end
    if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      last_wr_addr           <= bus.mem_addr;
      last_wr_data           <= bus.mem_wdata;
      wr_count               <= wr_count + 1;
    end
  end

  // Reference model: cycle numbers of expected events
  logic [31:0] ref_mem [256];
  int          rd_c = -1;
  int          wr_c = -1;
  int          done_c = -1;
  int          err_c = -1;
  int          free_c = 0;
  logic [31:0] exp_addr;
  logic [31:0] exp_data;
  int          done_at = -1;
  int          err_at = -1;
  int          done_n = 0;

  always @(negedge clk) begin
    logic [1:0]  t;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] old;
    logic        legal;
    int          sh;
    if (reset) begin
      chk("rst_mem_en", {31'b0, bus.mem_en}, 32'd0);
      chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
      chk("rst_done", {31'b0, bus.done}, 32'd0);
      chk("rst_err", {31'b0, bus.err}, 32'd0);
      chk("rst_ready", {31'b0, bus.req_ready}, 32'd1);
      rd_c = -1; wr_c = -1; done_c = -1; err_c = -1;
      free_c = 0;
    end else begin
      chk("ready", {31'b0, bus.req_ready}, {31'b0, cyc >= free_c});
      chk("mem_en", {31'b0, bus.mem_en},
          {31'b0, (cyc == rd_c) || (cyc == wr_c)});
      chk("mem_we", {31'b0, bus.mem_we}, {31'b0, cyc == wr_c});
      chk("done", {31'b0, bus.done}, {31'b0, cyc == done_c});
      chk("err", {31'b0, bus.err}, {31'b0, cyc == err_c});
      if (cyc == rd_c) chk("rd_addr", bus.mem_addr, exp_addr);
      if (cyc == wr_c) begin
        chk("wr_addr", bus.mem_addr, exp_addr);
        chk("wr_data", bus.mem_wdata, exp_data);
        ref_mem[exp_addr[9:2]] = exp_data;
      end
      if (bus.done) begin done_at = cyc; done_n++; end
      if (bus.err) err_at = cyc;
      if (cyc >= free_c && bus.req_valid) begin
        t = bus.req_type;
        a = bus.req_addr;
        d = bus.req_wdata;
        legal = (t == 2'b00) ? (a[1:0] == 2'b00) :
                (t == 2'b01) ? !a[0] : (t == 2'b10);
        if (!legal) begin
          err_c  = cyc + 1;
          free_c = cyc + 1;
        end else begin
          exp_addr = {a[31:2], 2'b00};
          old = ref_mem[a[9:2]];
          sh = 8 * int'(a[1:0]);
          if (t == 2'b00) exp_data = d;
          else if (t == 2'b01)
            exp_data = a[1] ? {d[15:0], old[15:0]}
                            : {old[31:16], d[15:0]};
          else
            exp_data = (old & ~(32'hFF << sh)) |
                       ({24'b0, d[7:0]} << sh);
          if (t == 2'b00) begin
            rd_c = -1; wr_c = cyc + 1;
            done_c = cyc + 2; free_c = cyc + 2;
          end else begin
            rd_c = cyc + 1; wr_c = cyc + 3;
            done_c = cyc + 4; free_c = cyc + 4;
          end
        end
      end
    end
  end

  int acc;

  task automatic store(input logic [1:0] t, input logic [31:0] a,
                       input logic [31:0] d, input int gap);
    bus.req_type  = t;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_valid = 1'b1;
    acc = cyc;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  initial begin
    int wc;
    int rc;
    int dn;
    for (int i = 0; i < 256; i++) begin
      mem[i] <= 32'h0;
      ref_mem[i] = 32'h0;
    end
    mem[8] <= 32'h11223344;
    ref_mem[8] = 32'h11223344;
    mem[9] <= 32'hA0B0C0D0;
    ref_mem[9] = 32'hA0B0C0D0;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_type  = 2'b00;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("ready_after_reset", {31'b0, bus.req_ready}, 32'd1);

    store(2'b00, 32'h10, 32'hDEADBEEF, 2);
    chk("word_addr", last_wr_addr, 32'h10);
    chk("word_data", last_wr_data, 32'hDEADBEEF);
    chk("word_no_read", rd_count, 32'd0);
    chk("word_latency", done_at - acc, 32'd2);

    store(2'b10, 32'h22, 32'h000000AB, 4);
    chk("byte_data", last_wr_data, 32'h11AB3344);
    chk("byte_reads", rd_count, 32'd1);
    chk("byte_latency", done_at - acc, 32'd4);

    store(2'b00, 32'h20, 32'h11223344, 1);
    store(2'b01, 32'h22, 32'h0000CAFE, 4);
    chk("half_hi_data", last_wr_data, 32'hCAFE3344);
    store(2'b00, 32'h20, 32'h11223344, 1);
    store(2'b01, 32'h20, 32'h0000CAFE, 4);
    chk("half_lo_data", last_wr_data, 32'h1122CAFE);
    chk("half_latency", done_at - acc, 32'd4);

    wc = wr_count;
    rc = rd_count;
    store(2'b01, 32'h21, 32'h1234, 1);
    chk("err_half_lat", err_at - acc, 32'd1);
    store(2'b00, 32'h12, 32'h1234, 1);
    chk("err_word_lat", err_at - acc, 32'd1);
    store(2'b11, 32'h20, 32'h1234, 1);
    chk("err_type_lat", err_at - acc, 32'd1);
    chk("err_no_write", wr_count, wc);
    chk("err_no_read", rd_count, rc);

    // Back-to-back byte stores, inputs changed mid-flight
    wc = wr_count;
    bus.req_type  = 2'b10;
    bus.req_addr  = 32'h24;
    bus.req_wdata = 32'h00000055;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_addr  = 32'h27;
    bus.req_wdata = 32'h00000066;
    repeat (3) begin @(posedge clk); #1; end
    chk("b2b_done_cycle", {31'b0, bus.done}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("b2b_writes", wr_count - wc, 32'd2);
    chk("b2b_mem", mem[9], 32'h66B0C055);

    // Reset during the merge cycle
    wc = wr_count;
    dn = done_n;
    store(2'b10, 32'h20, 32'h000000EE, 1);
    #1 reset = 1'b1;
    #1 chk("rst_mid_en", {31'b0, bus.mem_en}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_mid_no_done", done_n - dn, 32'd0);
    chk("rst_mid_no_write", wr_count - wc, 32'd0);
    store(2'b00, 32'h30, 32'h12345678, 2);
    chk("post_rst_data", last_wr_data, 32'h12345678);
    chk("post_rst_latency", done_at - acc, 32'd2);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
